// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: FIFO controller wrapping one single-port SRAM macro with a
// 1-cycle registered read. The RW port is arbitrated cycle by cycle between
// enqueue writes and prefetch reads; a 2-entry output buffer absorbs the read
// latency and consumer backpressure.
// Optional feature: define SRAM_FIFO_BYPASS_EN to let an enqueue skip the SRAM
// and land directly in the output buffer when nothing older is queued behind it.
module sram_fifo_ctrl #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int W     = 13
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          enq_valid,
  output logic          enq_ready,
  input  logic [W-1:0]  enq_bits,
  output logic          deq_valid,
  input  logic          deq_ready,
  output logic [W-1:0]  deq_bits,
  output logic [AW+1:0] count,
  output logic          ram_en,
  output logic          ram_wmode,
  output logic [AW-1:0] ram_addr,
  output logic [W-1:0]  ram_wdata,
  input  logic [W-1:0]  ram_rdata
);
  localparam int CW = AW + 1;  // ram_cnt holds 0..DEPTH
  localparam int NW = AW + 2;  // count holds 0..DEPTH+2

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] ram_cnt_q, ram_cnt_d;
  logic [NW-1:0] count_q, count_d;
  logic [1:0]    ob_cnt_q, ob_cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic          prio_q, prio_d;
  logic [W-1:0]  ob_q [2];
  logic [W-1:0]  ob_d [2];

  logic          deq_fire, enq_fire;
  logic [2:0]    space;
  logic          rd_req, wr_req, conflict;
  logic          rd_grant, wr_grant, bypass;
  logic          cap;
  logic [W-1:0]  cap_data;
  logic [1:0]    ob_keep;

  // Request generation, port arbitration and next-state computation.
  // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latches).
  always_comb begin
    deq_valid = (ob_cnt_q != 2'd0);
    deq_fire  = deq_valid & deq_ready;
    // Free output-buffer slots once this cycle's dequeue and any in-flight read are accounted for.
    space     = 3'd2 - {1'b0, ob_cnt_q} - {2'b0, rd_pend_q} + {2'b0, deq_fire};

    // Gating with reset_n keeps the handshake and RAM enable low while reset is held.
    rd_req    = reset_n & (ram_cnt_q != '0) & (space != 3'd0);
    wr_req    = reset_n & enq_valid & (ram_cnt_q < CW'(DEPTH));
    conflict  = rd_req & wr_req;
    rd_grant  = rd_req & (!wr_req | !prio_q);
    wr_grant  = wr_req & (!rd_req | prio_q);

    bypass    = 1'b0;
`ifdef SRAM_FIFO_BYPASS_EN
    // Only legal when nothing is stored in or being read from the RAM, so order is kept.
    bypass    = reset_n & enq_valid & (ram_cnt_q == '0) & !rd_pend_q
              & (space != 3'd0) & !rd_grant;
    wr_grant  = wr_grant & !bypass;
`endif

    enq_ready = wr_grant | bypass;
    enq_fire  = enq_valid & enq_ready;

    ram_en    = rd_grant | wr_grant;
    ram_wmode = wr_grant;
    ram_addr  = wr_grant ? wr_ptr_q : rd_ptr_q;
    ram_wdata = enq_bits;

    // Read data is valid only in the cycle after a granted read; bypass data comes straight from enq.
    cap       = rd_pend_q | bypass;
    cap_data  = rd_pend_q ? ram_rdata : enq_bits;

    wr_ptr_d  = wr_ptr_q + AW'(wr_grant);
    rd_ptr_d  = rd_ptr_q + AW'(rd_grant);
    ram_cnt_d = ram_cnt_q + CW'(wr_grant) - CW'(rd_grant);
    rd_pend_d = rd_grant;
    prio_d    = conflict ? ~prio_q : prio_q;
    count_d   = count_q + NW'(enq_fire) - NW'(deq_fire);

    // Shift on dequeue first, then the capture fills the first free slot.
    ob_keep   = ob_cnt_q - 2'(deq_fire);
    ob_d[0]   = deq_fire ? ob_q[1] : ob_q[0];
    ob_d[1]   = ob_q[1];
    if (cap) begin
      if (ob_keep == 2'd0) ob_d[0] = cap_data;
      else                 ob_d[1] = cap_data;
    end
    ob_cnt_d  = ob_keep + 2'(cap);

    deq_bits  = ob_q[0];
    count     = count_q;
  end

  // Control state: pointers, occupancy counters, read-pending flag and arbitration priority.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      count_q   <= '0;
      ob_cnt_q  <= 2'd0;
      rd_pend_q <= 1'b0;
      prio_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      count_q   <= count_d;
      ob_cnt_q  <= ob_cnt_d;
      rd_pend_q <= rd_pend_d;
      prio_q    <= prio_d;
    end
  end

  // Output buffer data storage.
  // NOTE: data storage is not reset; ob_cnt_q alone decides which entries are meaningful.
  always_ff @(posedge clock) begin
    ob_q[0] <= ob_d[0];
    ob_q[1] <= ob_d[1];
  end

  // A capture must always find a free slot in the output buffer.
  ob_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(cap && (ob_keep == 2'd2)));

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Testbench for sram_fifo_ctrl: SRAM behavioural model, scoreboard queue filled
// on every accepted enqueue and a monitor that pops and compares on every dequeue.
`timescale 1ns/1ps
module tb_sram_fifo_ctrl;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int W     = 13;
`ifdef SRAM_FIFO_BYPASS_EN
  localparam int EXP_LAT    = 1;
  localparam int EXP_STREAM = 200;
`else
  localparam int EXP_LAT    = 3;
  localparam int EXP_STREAM = 100;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          enq_valid = 1'b0;
  logic          enq_ready;
  logic [W-1:0]  enq_bits = '0;
  logic          deq_valid;
  logic          deq_ready = 1'b0;
  logic [W-1:0]  deq_bits;
  logic [AW+1:0] count;
  logic          ram_en;
  logic          ram_wmode;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_wdata;
  logic [W-1:0]  ram_rdata = '0;

  sram_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .W(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_bits  (enq_bits),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_bits  (deq_bits),
    .count     (count),
    .ram_en    (ram_en),
    .ram_wmode (ram_wmode),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clock = ~clock;

  // Single-port SRAM model; rdata carries junk in any cycle not preceded by a read.
  logic [W-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (ram_en && ram_wmode) mem[ram_addr] <= ram_wdata;
    if (ram_en && !ram_wmode) ram_rdata <= mem[ram_addr];
    else                      ram_rdata <= W'($urandom);
  end

  int checks = 0;
  int errors = 0;
  int enq_total = 0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] mon_exp;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus side: every accepted enqueue pushes its data as the expected output.
  always @(negedge clock) begin
    if (reset_n && enq_valid && enq_ready) begin
      exp_q.push_back(enq_bits);
      enq_total++;
    end
  end

  // Monitor: every dequeue pops the oldest expected entry and compares.
  always @(negedge clock) begin
    if (reset_n && deq_valid && deq_ready) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "deq_unexpected", int'(deq_bits), 0);
      end else begin
        mon_exp = exp_q.pop_front();
        check(deq_bits == mon_exp, "deq_data", int'(deq_bits), int'(mon_exp));
      end
    end
  end

  // Offer n entries (data = base + k*stride); optionally randomise deq_ready per cycle.
  task automatic push_n(input int n, input int base, input int stride, input bit rand_deq,
                        input int budget, output int sent);
    int cyc;
    sent = 0;
    cyc = 0;
    enq_valid = 1'b1;
    while (sent < n && cyc < budget) begin
      enq_bits = W'(base + sent * stride);
      if (rand_deq) deq_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      if (enq_ready) sent++;
      @(posedge clock); #1;
      cyc++;
    end
    enq_valid = 1'b0;
    if (rand_deq) deq_ready = 1'b0;
  endtask

  // Dequeue until empty (bounded), then confirm the block is idle.
  task automatic drain(input int budget, input string name);
    int cyc;
    cyc = 0;
    deq_ready = 1'b1;
    while (count != 0 && cyc < budget) begin
      @(posedge clock); #1;
      cyc++;
    end
    check(count == 0, name, int'(count), 0);
    check(exp_q.size() == 0, {name, "_sb_empty"}, exp_q.size(), 0);
    @(negedge clock);
    check(!deq_valid && !ram_en, {name, "_idle"}, int'({deq_valid, ram_en}), 0);
    @(posedge clock); #1;
    deq_ready = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int got;
    int lat;
    int f0;
    int f1;
    int bad;
    logic prev_w;

    // ---- 1: reset values, single entry latency ----
    enq_valid = 1'b1;
    enq_bits  = 13'h0001;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check(enq_ready == 1'b0, "rst_enq_ready", int'(enq_ready), 0);
    check(deq_valid == 1'b0, "rst_deq_valid", int'(deq_valid), 0);
    check(ram_en == 1'b0, "rst_ram_en", int'(ram_en), 0);
    check(count == 0, "rst_count", int'(count), 0);
    enq_valid = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    enq_valid = 1'b1;
    enq_bits  = 13'h0001;
    @(negedge clock);
    check(enq_ready == 1'b1, "t1_enq_ready", int'(enq_ready), 1);
`ifdef SRAM_FIFO_BYPASS_EN
    check(ram_en == 1'b0, "t1_bypass_no_ram", int'(ram_en), 0);
`else
    check(ram_en && ram_wmode, "t1_write_grant", int'({ram_en, ram_wmode}), 3);
    check(ram_addr == 0, "t1_write_addr", int'(ram_addr), 0);
`endif
    @(posedge clock); #1;
    enq_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (deq_valid) begin
        lat = c;
        break;
      end
    end
    check(lat == EXP_LAT, "t1_latency", lat, EXP_LAT);
    check(count == 1, "t1_count", int'(count), 1);
    drain(20, "t1_drain");

    // ---- 2: fill to capacity with consumer stalled, then drain in order ----
    push_n(258, 0, 1, 1'b0, 1000, got);
    check(got == 258, "t2_accepted", got, 258);
    enq_valid = 1'b1;
    enq_bits  = 13'h1FFF;
    @(negedge clock);
    check(enq_ready == 1'b0, "t2_full_enq_ready", int'(enq_ready), 0);
    check(count == 258, "t2_full_count", int'(count), 258);
    check(ram_en == 1'b0, "t2_full_ram_idle", int'(ram_en), 0);
    @(posedge clock); #1;
    enq_valid = 1'b0;
    drain(1000, "t2_drain");

    // ---- 3: continuous stream, consumer always ready ----
    deq_ready = 1'b1;
    bad = 0;
    f0 = 0;
    f1 = 0;
    fork
      push_n(1000, 5, 37, 1'b0, 2600, got);
      begin
        repeat (300) @(negedge clock);
        prev_w = ram_wmode;
        #1 f0 = enq_total;
        for (int c = 0; c < 200; c++) begin
          @(negedge clock);
`ifdef SRAM_FIFO_BYPASS_EN
          if (ram_en) bad++;
`else
          if (!ram_en || ram_wmode == prev_w) bad++;
`endif
          prev_w = ram_wmode;
        end
        #1 f1 = enq_total;
      end
    join
    check(got == 1000, "t3_accepted", got, 1000);
    check(f1 - f0 == EXP_STREAM, "t3_throughput", f1 - f0, EXP_STREAM);
    check(bad == 0, "t3_grant_pattern", bad, 0);
    drain(50, "t3_drain");

    // ---- 4: random backpressure under full enqueue pressure ----
    push_n(600, 13'h0AB, 11, 1'b1, 4000, got);
    check(got == 600, "t4_accepted", got, 600);
    drain(700, "t4_drain");

    // ---- 5: reset with occupancy and a read in flight ----
    push_n(101, 13'h100, 3, 1'b0, 600, got);
    check(got == 101, "t5_accepted", got, 101);
    deq_ready = 1'b1;
    @(negedge clock);
    check(ram_en && !ram_wmode, "t5_read_issued", int'({ram_en, ram_wmode}), 2);
    check(count == 101, "t5_count_pre", int'(count), 101);
    @(posedge clock); #2;
    reset_n   = 1'b0;
    enq_valid = 1'b1;
    exp_q.delete();
    #1;
    check(enq_ready == 1'b0, "t5_rst_enq_ready", int'(enq_ready), 0);
    check(deq_valid == 1'b0, "t5_rst_deq_valid", int'(deq_valid), 0);
    check(ram_en == 1'b0, "t5_rst_ram_en", int'(ram_en), 0);
    check(count == 0, "t5_rst_count", int'(count), 0);
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;
    enq_valid = 1'b1;
    enq_bits  = 13'h1ABC;
    @(posedge clock); #1;
    enq_valid = 1'b0;
    lat = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (deq_valid) begin
        lat = c;
        break;
      end
    end
    check(deq_valid == 1'b1, "t5_post_valid", int'(deq_valid), 1);
    check(deq_bits == 13'h1ABC, "t5_post_head", int'(deq_bits), 'h1ABC);
    check(count == 1, "t5_post_count", int'(count), 1);
    drain(20, "t5_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
